// File: rtl/prf_pkg.sv
// Shared constants and types for the banked integer physical register file.
package prf_pkg;

    localparam int PRF_DATA_W     = 32;
    localparam int PRF_NUM_REGS   = 64;
    localparam int PRF_RD_WAYS    = 4;
    localparam int PRF_WR_WAYS    = 4;
    localparam int PRF_ALLOC_WAYS = 4;

    // Index width for a register file of the given depth.
    function automatic int idx_width(input int regs);
        return $clog2(regs);
    endfunction

    localparam int PRF_IDX_W = idx_width(PRF_NUM_REGS);

    // Where a captured operand comes from; shared with the source-select wrapper.
    typedef enum logic [1:0] {
        RS_ARRAY  = 2'd0,
        RS_BYPASS = 2'd1,
        RS_ZERO   = 2'd2
    } rs_source;

endpackage

// File: rtl/prf_bank.sv
// One register bank: NUM_REGS x DATA_W, two combinational read ports,
// WR_WAYS write ports with the highest-numbered way winning, r0 fixed at zero.
module prf_bank
    import prf_pkg::*;
#(
    parameter int DATA_W   = PRF_DATA_W,
    parameter int NUM_REGS = PRF_NUM_REGS,
    parameter int WR_WAYS  = PRF_WR_WAYS
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [WR_WAYS-1:0]                         wr_en,
    input  logic [WR_WAYS-1:0][$clog2(NUM_REGS)-1:0]   wr_index,
    input  logic [WR_WAYS-1:0][DATA_W-1:0]             wr_data,
    input  logic [$clog2(NUM_REGS)-1:0]                rd_index_a,
    input  logic [$clog2(NUM_REGS)-1:0]                rd_index_b,
    output logic [DATA_W-1:0]                          rd_data_a,
    output logic [DATA_W-1:0]                          rd_data_b
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;

    // Storage update; later ways overwrite earlier ones, r0 is never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem <= '0;
        end else begin
            for (int w = 0; w < WR_WAYS; w++) begin
                if (wr_en[w] && (wr_index[w] != IDX_W'(0))) begin
                    mem[wr_index[w]] <= wr_data[w];
                end
            end
        end
    end

    assign rd_data_a = (rd_index_a == IDX_W'(0)) ? '0 : mem[rd_index_a];
    assign rd_data_b = (rd_index_b == IDX_W'(0)) ? '0 : mem[rd_index_b];

endmodule

// File: rtl/prf_banked.sv
// Banked physical register file with same-cycle write bypass, a per-register
// ready scoreboard and a single-entry registered read stage (valid/ready).
module prf_banked
    import prf_pkg::*;
#(
    parameter int DATA_W     = PRF_DATA_W,
    parameter int NUM_REGS   = PRF_NUM_REGS,
    parameter int RD_WAYS    = PRF_RD_WAYS,
    parameter int WR_WAYS    = PRF_WR_WAYS,
    parameter int ALLOC_WAYS = PRF_ALLOC_WAYS
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          flush,
    input  logic [RD_WAYS-1:0]                            req_valid,
    input  logic [RD_WAYS-1:0][$clog2(NUM_REGS)-1:0]      rs1_index,
    input  logic [RD_WAYS-1:0][$clog2(NUM_REGS)-1:0]      rs2_index,
    output logic                                          req_ready,
    output logic [RD_WAYS-1:0]                            out_valid,
    output logic [RD_WAYS-1:0][DATA_W-1:0]                rs1_data,
    output logic [RD_WAYS-1:0][DATA_W-1:0]                rs2_data,
    input  logic                                          out_ready,
    input  logic [WR_WAYS-1:0]                            wb_en,
    input  logic [WR_WAYS-1:0][$clog2(NUM_REGS)-1:0]      wb_index,
    input  logic [WR_WAYS-1:0][DATA_W-1:0]                wb_data,
    input  logic [ALLOC_WAYS-1:0]                         alloc_en,
    input  logic [ALLOC_WAYS-1:0][$clog2(NUM_REGS)-1:0]   alloc_index,
    output logic [NUM_REGS-1:0]                           ready_vec
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [RD_WAYS-1:0][DATA_W-1:0] bank_rs1, bank_rs2;
    logic [RD_WAYS-1:0][DATA_W-1:0] cap_rs1_p0, cap_rs2_p0;
    logic [RD_WAYS-1:0]             vld_p1;
    logic [RD_WAYS-1:0][DATA_W-1:0] rs1_p1, rs2_p1;
    logic [NUM_REGS-1:0]            ready_p1;
    logic                           req_fire;

    // Operand value at accept: array value, overridden by the last matching
    // same-cycle writeback, with r0 always reading as zero.
    function automatic logic [DATA_W-1:0] capture(
        input logic [IDX_W-1:0]                idx,
        input logic [DATA_W-1:0]               arr_val,
        input logic [WR_WAYS-1:0]              en,
        input logic [WR_WAYS-1:0][IDX_W-1:0]   widx,
        input logic [WR_WAYS-1:0][DATA_W-1:0]  wdat
    );
        logic [DATA_W-1:0] byp;
        logic [DATA_W-1:0] result;
        rs_source          src;
        byp = '0;
        src = RS_ARRAY;
        for (int w = 0; w < WR_WAYS; w++) begin
            if (en[w] && (widx[w] == idx)) begin
                byp = wdat[w];
                src = RS_BYPASS;
            end
        end
        if (idx == IDX_W'(0)) src = RS_ZERO;
        case (src)
            RS_BYPASS: result = byp;
            RS_ZERO:   result = '0;
            default:   result = arr_val;
        endcase
        return result;
    endfunction

    // One bank per issue way; every write fans out to all of them.
    for (genvar i = 0; i < RD_WAYS; i++) begin : g_bank
        prf_bank #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .WR_WAYS  (WR_WAYS)
        ) u_bank (
            .clock      (clock),
            .reset      (reset),
            .wr_en      (wb_en),
            .wr_index   (wb_index),
            .wr_data    (wb_data),
            .rd_index_a (rs1_index[i]),
            .rd_index_b (rs2_index[i]),
            .rd_data_a  (bank_rs1[i]),
            .rd_data_b  (bank_rs2[i])
        );
    end

    assign req_ready = !(|vld_p1) || out_ready;
    assign req_fire  = req_ready && (|req_valid);

    // Stage p0: bypassed operand selection for every way.
    always_comb begin
        cap_rs1_p0 = '0;
        cap_rs2_p0 = '0;
        for (int i = 0; i < RD_WAYS; i++) begin
            cap_rs1_p0[i] = capture(rs1_index[i], bank_rs1[i], wb_en, wb_index, wb_data);
            cap_rs2_p0[i] = capture(rs2_index[i], bank_rs2[i], wb_en, wb_index, wb_data);
        end
    end

    // Stage p1: single-entry output register; flush beats accept, hold on stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= '0;
            rs1_p1 <= '0;
            rs2_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= '0;
        end else if (req_fire) begin
            vld_p1 <= req_valid;
            rs1_p1 <= cap_rs1_p0;
            rs2_p1 <= cap_rs2_p0;
        end else if (out_ready) begin
            vld_p1 <= '0;
        end
    end

    // Scoreboard: writeback sets, allocation clears and wins; r0 stays ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_p1 <= '1;
        end else begin
            for (int w = 0; w < WR_WAYS; w++) begin
                if (wb_en[w]) ready_p1[wb_index[w]] <= 1'b1;
            end
            for (int a = 0; a < ALLOC_WAYS; a++) begin
                if (alloc_en[a] && (alloc_index[a] != IDX_W'(0))) begin
                    ready_p1[alloc_index[a]] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign rs1_data  = rs1_p1;
    assign rs2_data  = rs2_p1;
    assign ready_vec = ready_p1;

endmodule

// File: tb/tb_prf_banked.sv
// Bench for prf_banked: directed vector table, reset-mid-stall sequence and
// randomized traffic checked against a behavioural model of the register file.
module tb_prf_banked;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  flush = 1'b0;
    logic                  out_ready = 1'b1;
    logic [3:0]            req_valid = '0;
    logic [3:0][5:0]       rs1_index = '0;
    logic [3:0][5:0]       rs2_index = '0;
    logic                  req_ready;
    logic [3:0]            out_valid;
    logic [3:0][31:0]      rs1_data;
    logic [3:0][31:0]      rs2_data;
    logic [3:0]            wb_en = '0;
    logic [3:0][5:0]       wb_index = '0;
    logic [3:0][31:0]      wb_data = '0;
    logic [3:0]            alloc_en = '0;
    logic [3:0][5:0]       alloc_index = '0;
    logic [63:0]           ready_vec;

    prf_banked dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .rs1_index   (rs1_index),
        .rs2_index   (rs2_index),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_ready   (out_ready),
        .wb_en       (wb_en),
        .wb_index    (wb_index),
        .wb_data     (wb_data),
        .alloc_en    (alloc_en),
        .alloc_index (alloc_index),
        .ready_vec   (ready_vec)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic last_rr = 1'b0;

    // Behavioural model state
    logic [31:0] m_mem [64];
    logic [63:0] m_ready = '1;
    logic [3:0]  m_vld = '0;
    logic [31:0] m_rs1 [4];
    logic [31:0] m_rs2 [4];

    typedef struct {
        int rd, way, s1, s2;
        int w0, p0, i0; logic [31:0] d0;
        int w1, p1, i1; logic [31:0] d1;
        int al, ai, fl, ordy;
        int e_vld, e_way; logic [31:0] e_r1, e_r2;
        int e_idx, e_bit, e_rr;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        flush = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        rs1_index = '0;
        rs2_index = '0;
        wb_en = '0;
        wb_index = '0;
        wb_data = '0;
        alloc_en = '0;
        alloc_index = '0;
    endtask

    // One clock: check req_ready, advance the model by the rules, compare outputs.
    task automatic tick();
        logic [31:0] nm [64];
        logic [63:0] nr;
        logic        rr, fire;
        #1;
        rr = (m_vld == 4'd0) || out_ready;
        if (!reset) check("req_ready", 64'(req_ready), 64'(rr));
        last_rr = req_ready;
        if (reset) begin
            for (int r = 0; r < 64; r++) m_mem[r] = '0;
            m_ready = '1;
            m_vld = '0;
            for (int i = 0; i < 4; i++) begin m_rs1[i] = '0; m_rs2[i] = '0; end
        end else begin
            nm = m_mem;
            for (int w = 0; w < 4; w++)
                if (wb_en[w] && wb_index[w] != 6'd0) nm[wb_index[w]] = wb_data[w];
            nr = m_ready;
            for (int w = 0; w < 4; w++) if (wb_en[w]) nr[wb_index[w]] = 1'b1;
            for (int a = 0; a < 4; a++) if (alloc_en[a]) nr[alloc_index[a]] = 1'b0;
            nr[0] = 1'b1;
            fire = rr && (req_valid != 4'd0);
            if (flush) m_vld = '0;
            else if (fire) begin
                m_vld = req_valid;
                for (int i = 0; i < 4; i++) begin
                    m_rs1[i] = nm[rs1_index[i]];
                    m_rs2[i] = nm[rs2_index[i]];
                end
            end else if (out_ready) m_vld = '0;
            m_mem = nm;
            m_ready = nr;
        end
        @(posedge clock);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_vld));
        for (int i = 0; i < 4; i++) begin
            if (m_vld[i]) begin
                check($sformatf("rs1_data[%0d]", i), 64'(rs1_data[i]), 64'(m_rs1[i]));
                check($sformatf("rs2_data[%0d]", i), 64'(rs2_data[i]), 64'(m_rs2[i]));
            end
        end
        check("ready_vec", ready_vec, m_ready);
    endtask

    task automatic apply(input vec_t r);
        clear_inputs();
        if (r.rd != 0) begin
            req_valid[r.way] = 1'b1;
            rs1_index[r.way] = 6'(r.s1);
            rs2_index[r.way] = 6'(r.s2);
        end
        if (r.w0 != 0) begin
            wb_en[r.p0] = 1'b1; wb_index[r.p0] = 6'(r.i0); wb_data[r.p0] = r.d0;
        end
        if (r.w1 != 0) begin
            wb_en[r.p1] = 1'b1; wb_index[r.p1] = 6'(r.i1); wb_data[r.p1] = r.d1;
        end
        if (r.al != 0) begin
            alloc_en[0] = 1'b1; alloc_index[0] = 6'(r.ai);
        end
        flush = (r.fl != 0);
        out_ready = (r.ordy != 0);
    endtask

    initial begin
        //            rd way s1 s2  w0 p0 i0 d0            w1 p1 i1 d1      al ai  fl ordy e_vld e_way e_r1          e_r2          idx bit rr
        tbl[0]  = '{1, 0, 5, 0,  0, 0, 0, 0,             0, 0, 0, 0,      0, 0,  0, 1,   1, 0, 0,             0,             5,  1, 1};
        tbl[1]  = '{0, 0, 0, 0,  1, 2, 7, 32'hDEADBEEF,  0, 0, 0, 0,      0, 0,  0, 1,   0, 0, 0,             0,             7,  1, 1};
        tbl[2]  = '{1, 3, 7, 7,  0, 0, 0, 0,             0, 0, 0, 0,      0, 0,  0, 1,   8, 3, 32'hDEADBEEF,  32'hDEADBEEF,  7,  1, 1};
        tbl[3]  = '{1, 1, 9, 7,  1, 0, 9, 32'h11,        1, 1, 9, 32'h22, 0, 0,  0, 1,   2, 1, 32'h22,        32'hDEADBEEF,  9,  1, 1};
        tbl[4]  = '{1, 2, 9, 0,  0, 0, 0, 0,             0, 0, 0, 0,      0, 0,  0, 1,   4, 2, 32'h22,        0,             9,  1, 1};
        tbl[5]  = '{0, 0, 0, 0,  0, 0, 0, 0,             0, 0, 0, 0,      1, 12, 0, 1,   0, 0, 0,             0,             12, 0, 1};
        tbl[6]  = '{0, 0, 0, 0,  1, 3, 12, 32'h1234,     0, 0, 0, 0,      0, 0,  0, 1,   0, 0, 0,             0,             12, 1, 1};
        tbl[7]  = '{0, 0, 0, 0,  1, 0, 12, 32'h5678,     0, 0, 0, 0,      1, 12, 0, 1,   0, 0, 0,             0,             12, 0, 1};
        tbl[8]  = '{0, 0, 0, 0,  0, 0, 0, 0,             1, 1, 0, 32'h55, 0, 0,  0, 1,   0, 0, 0,             0,             0,  1, 1};
        tbl[9]  = '{1, 0, 0, 12, 0, 0, 0, 0,             0, 0, 0, 0,      0, 0,  0, 1,   1, 0, 0,             32'h5678,      12, 0, 1};
        tbl[10] = '{1, 0, 7, 7,  0, 0, 0, 0,             0, 0, 0, 0,      0, 0,  1, 1,   0, 0, 0,             0,             7,  1, 1};
        tbl[11] = '{1, 2, 7, 9,  0, 0, 0, 0,             0, 0, 0, 0,      0, 0,  0, 1,   4, 2, 32'hDEADBEEF,  32'h22,        7,  1, 1};
        tbl[12] = '{1, 0, 9, 9,  1, 0, 7, 32'hCAFE,      0, 0, 0, 0,      0, 0,  0, 0,   4, 2, 32'hDEADBEEF,  32'h22,        7,  1, 0};
        tbl[13] = '{1, 0, 9, 9,  1, 0, 7, 32'hCAFE,      0, 0, 0, 0,      0, 0,  0, 0,   4, 2, 32'hDEADBEEF,  32'h22,        7,  1, 0};
        tbl[14] = '{1, 0, 9, 9,  1, 0, 7, 32'hCAFE,      0, 0, 0, 0,      0, 0,  0, 0,   4, 2, 32'hDEADBEEF,  32'h22,        7,  1, 0};
        tbl[15] = '{1, 0, 9, 7,  0, 0, 0, 0,             0, 0, 0, 0,      0, 0,  0, 1,   1, 0, 32'h22,        32'hCAFE,      7,  1, 1};

        // Reset
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_ready_vec", ready_vec, '1);
        check("reset_rs1_data0", 64'(rs1_data[0]), 64'd0);

        // Directed vectors
        for (int n = 0; n < 16; n++) begin
            apply(tbl[n]);
            tick();
            check($sformatf("tbl%0d_req_ready", n), 64'(last_rr), 64'(tbl[n].e_rr));
            check($sformatf("tbl%0d_out_valid", n), 64'(out_valid), 64'(tbl[n].e_vld));
            if (tbl[n].e_vld != 0) begin
                check($sformatf("tbl%0d_rs1", n), 64'(rs1_data[tbl[n].e_way]), 64'(tbl[n].e_r1));
                check($sformatf("tbl%0d_rs2", n), 64'(rs2_data[tbl[n].e_way]), 64'(tbl[n].e_r2));
            end
            check($sformatf("tbl%0d_ready_bit", n), 64'(ready_vec[tbl[n].e_idx]), 64'(tbl[n].e_bit));
        end

        // Reset in the middle of a stall discards the held entry and clears the array
        clear_inputs();
        out_ready = 1'b0;
        tick();
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midstall_reset_valid", 64'(out_valid), 64'd0);
        check("midstall_reset_rs1", 64'(rs1_data[0]), 64'd0);
        check("midstall_reset_ready", ready_vec, '1);
        clear_inputs();
        req_valid[0] = 1'b1;
        rs1_index[0] = 6'd7;
        rs2_index[0] = 6'd9;
        tick();
        check("post_reset_valid", 64'(out_valid), 64'd1);
        check("post_reset_r7", 64'(rs1_data[0]), 64'd0);
        check("post_reset_r9", 64'(rs2_data[0]), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                rs1_index[i] = 6'($urandom_range(0, 15));
                rs2_index[i] = 6'($urandom_range(0, 15));
                wb_index[i] = 6'($urandom_range(0, 15));
                wb_data[i] = $urandom;
                alloc_index[i] = 6'($urandom_range(0, 15));
            end
            wb_en = 4'($urandom);
            alloc_en = 4'($urandom & $urandom & $urandom);
            flush = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
